ecc_result_collector: RTL and testbench

Downstream capture stage for the ECC encoder/decoder top. It samples the `data_out`/`num_of_errors` pair on every `operation_done` pulse and stores it in a small result FIFO. Results are presented on a valid/ready stream to the consumer (host bridge or scoreboard logic). It also keeps saturating per-class error statistics and a sticky overflow flag, so bursts of operations are never silently lost.

---
 rtl/ecc_pkg.sv | 39 +++
 rtl/ecc_result_collector_if.sv | 37 +++
 rtl/ecc_sync_fifo.sv | 78 +++++++
 rtl/ecc_result_collector.sv | 126 ++++++++++++
 tb/tb_ecc_result_collector.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_pkg.sv
// Shared types, error-class constants and helpers for the ECC result path.
package ecc_pkg;

  // Nominal width of the ECC top data_out bus.
  localparam int unsigned ECC_DATA_WIDTH = 32;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_SINGLE = 2'd1;
  localparam logic [1:0] ERR_DOUBLE = 2'd2;

  typedef struct packed {
    logic [1:0]                errors;
    logic [ECC_DATA_WIDTH-1:0] data;
  } ecc_result_t;

  typedef enum logic [1:0] {
    ClassClean,
    ClassSingle,
    ClassMulti
  } err_class_e;

  // Codes 2 and 3 are both treated as uncorrectable (multi-bit).
  function automatic err_class_e classify(input logic [1:0] code);
    if (code == ERR_NONE) begin
      return ClassClean;
    end else if (code == ERR_SINGLE) begin
      return ClassSingle;
    end
    return ClassMulti;
  endfunction

  // Saturating increment for a counter of 'width' bits (1..64) held zero-extended in 64 bits.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_val) ? max_val : value + 64'd1;
  endfunction

endpackage

// File: rtl/ecc_result_collector_if.sv
// Capture strobe from the ECC top plus the valid/ready result stream to the consumer.
interface ecc_result_collector_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  operation_done;
  logic [DATA_WIDTH-1:0] data_in;
  logic [1:0]            errors_in;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            out_errors;

  // Producer of results and consumer of the stream (ECC top + host side).
  modport master (
    output operation_done,
    output data_in,
    output errors_in,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_errors
  );

  // The collector itself.
  modport slave (
    input  operation_done,
    input  data_in,
    input  errors_in,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_errors
  );

endinterface

// File: rtl/ecc_sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter and synchronous flush.
module ecc_sync_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [CntW-1:0]  count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A push into a full FIFO is only legal when the head leaves in the same edge.
  assign do_push = push && (!full || do_pop);
  assign do_pop  = pop && !empty;

  // Head is forced to zero while empty so the output is defined out of reset.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // Occupancy next-state.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: ;
    endcase
  end

  // Pointer and occupancy registers; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

  // Storage write; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/ecc_result_collector.sv
// Captures ECC results into a FIFO, streams them out and keeps drop/error statistics.
module ecc_result_collector
  import ecc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  ecc_result_collector_if.slave   bus,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    overflow,
  output logic [STAT_WIDTH-1:0]   drop_cnt,
  output logic [STAT_WIDTH-1:0]   cnt_clean,
  output logic [STAT_WIDTH-1:0]   cnt_single,
  output logic [STAT_WIDTH-1:0]   cnt_multi
);

  localparam int unsigned EntryW = DATA_WIDTH + 2;

  logic                  fifo_empty;
  logic                  fifo_full;
  logic [EntryW-1:0]     head;
  logic                  push_req;
  logic                  pop;
  logic                  accept;
  logic                  drop;

  logic                  overflow_q,   overflow_d;
  logic [STAT_WIDTH-1:0] drop_cnt_q,   drop_cnt_d;
  logic [STAT_WIDTH-1:0] cnt_clean_q,  cnt_clean_d;
  logic [STAT_WIDTH-1:0] cnt_single_q, cnt_single_d;
  logic [STAT_WIDTH-1:0] cnt_multi_q,  cnt_multi_d;

  function automatic logic [STAT_WIDTH-1:0] bump(input logic [STAT_WIDTH-1:0] v);
    logic [63:0] wide;
    wide = sat_inc(64'(v), STAT_WIDTH);
    return wide[STAT_WIDTH-1:0];
  endfunction

  // A push attempt in a clear cycle is discarded entirely, including its statistics.
  assign push_req = bus.operation_done && !clear;
  assign pop      = !fifo_empty && bus.out_ready;
  assign accept   = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  ecc_sync_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clear),
    .push  (accept),
    .pop   (pop),
    .wdata ({bus.errors_in, bus.data_in}),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_valid  = !fifo_empty;
  assign bus.out_data   = head[DATA_WIDTH-1:0];
  assign bus.out_errors = head[DATA_WIDTH +: 2];

  assign full       = fifo_full;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;
  assign cnt_clean  = cnt_clean_q;
  assign cnt_single = cnt_single_q;
  assign cnt_multi  = cnt_multi_q;

  // Statistics and overflow next-state; every push attempt is classified, accepted or not.
  always_comb begin
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;
    cnt_clean_d  = cnt_clean_q;
    cnt_single_d = cnt_single_q;
    cnt_multi_d  = cnt_multi_q;
    if (clear) begin
      overflow_d   = 1'b0;
      drop_cnt_d   = '0;
      cnt_clean_d  = '0;
      cnt_single_d = '0;
      cnt_multi_d  = '0;
    end else begin
      if (push_req) begin
        unique case (classify(bus.errors_in))
          ClassClean:  cnt_clean_d  = bump(cnt_clean_q);
          ClassSingle: cnt_single_d = bump(cnt_single_q);
          default:     cnt_multi_d  = bump(cnt_multi_q);
        endcase
      end
      if (drop) begin
        overflow_d = 1'b1;
        drop_cnt_d = bump(drop_cnt_q);
      end
    end
  end

  // Statistics and overflow registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
      cnt_clean_q  <= '0;
      cnt_single_q <= '0;
      cnt_multi_q  <= '0;
    end else begin
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      cnt_clean_q  <= cnt_clean_d;
      cnt_single_q <= cnt_single_d;
      cnt_multi_q  <= cnt_multi_d;
    end
  end

  // Accepted entries always carry the attempt; keeps the relation visible in the code.
  logic unused_accept;
  assign unused_accept = accept & 1'b0;

endmodule

// File: tb/tb_ecc_result_collector.sv
// Directed, table-driven bench for ecc_result_collector.
module tb_ecc_result_collector;

  logic clk;
  logic rst;
  logic clear;
  logic clear_b;

  logic [3:0]  count_a;
  logic        full_a, ovf_a;
  logic [15:0] drop_a, clean_a, single_a, multi_a;

  logic [3:0]  count_b;
  logic        full_b, ovf_b;
  logic [3:0]  drop_b, clean_b, single_b, multi_b;

  int n_tests;
  int n_fail;
  logic dead_seen;

  ecc_result_collector_if #(.DATA_WIDTH(32)) bus_a ();
  ecc_result_collector_if #(.DATA_WIDTH(32)) bus_b ();

  ecc_result_collector #(
    .DATA_WIDTH (32),
    .DEPTH      (8),
    .STAT_WIDTH (16)
  ) dut_a (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .bus        (bus_a),
    .count      (count_a),
    .full       (full_a),
    .overflow   (ovf_a),
    .drop_cnt   (drop_a),
    .cnt_clean  (clean_a),
    .cnt_single (single_a),
    .cnt_multi  (multi_a)
  );

  ecc_result_collector #(
    .DATA_WIDTH (32),
    .DEPTH      (8),
    .STAT_WIDTH (4)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear_b),
    .bus        (bus_b),
    .count      (count_b),
    .full       (full_b),
    .overflow   (ovf_b),
    .drop_cnt   (drop_b),
    .cnt_clean  (clean_b),
    .cnt_single (single_b),
    .cnt_multi  (multi_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watch for the dropped word ever surfacing on the stream.
  always @(negedge clk) begin
    if (bus_a.out_valid === 1'b1 && bus_a.out_data === 32'hDEAD) dead_seen = 1'b1;
  end

  typedef struct {
    logic        clr;
    logic        op;
    logic [31:0] din;
    logic [1:0]  err;
    logic        rdy;
    logic        exp_valid;
    logic        chk_data;
    logic [31:0] exp_data;
    logic [1:0]  exp_errs;
    logic [3:0]  exp_count;
    logic        exp_full;
    logic        exp_ovf;
    logic [15:0] exp_drop;
    logic [15:0] exp_clean;
    logic [15:0] exp_single;
    logic [15:0] exp_multi;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic clr, input logic op, input logic [31:0] din,
                         input logic [1:0] err, input logic rdy, input logic valid,
                         input logic chk, input logic [31:0] data, input logic [1:0] errs,
                         input logic [3:0] cnt, input logic fl, input logic ovf,
                         input logic [15:0] drp, input logic [15:0] cl, input logic [15:0] sg,
                         input logic [15:0] mu);
    vec_t v;
    v.clr = clr; v.op = op; v.din = din; v.err = err; v.rdy = rdy;
    v.exp_valid = valid; v.chk_data = chk; v.exp_data = data; v.exp_errs = errs;
    v.exp_count = cnt; v.exp_full = fl; v.exp_ovf = ovf; v.exp_drop = drp;
    v.exp_clean = cl; v.exp_single = sg; v.exp_multi = mu;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_a_zero(input string name);
    check({name, "_valid"},  0, bus_a.out_valid, 0);
    check({name, "_count"},  0, count_a, 0);
    check({name, "_full"},   0, full_a, 0);
    check({name, "_ovf"},    0, ovf_a, 0);
    check({name, "_drop"},   0, drop_a, 0);
    check({name, "_clean"},  0, clean_a, 0);
    check({name, "_single"}, 0, single_a, 0);
    check({name, "_multi"},  0, multi_a, 0);
    check({name, "_data"},   0, bus_a.out_data, 0);
    check({name, "_errs"},   0, bus_a.out_errors, 0);
  endtask

  initial begin
    vec_t v;
    n_tests = 0;
    n_fail = 0;
    dead_seen = 1'b0;
    rst = 1'b0;
    clear = 1'b0;
    clear_b = 1'b0;
    bus_a.operation_done = 1'b0; bus_a.data_in = '0; bus_a.errors_in = '0; bus_a.out_ready = 1'b0;
    bus_b.operation_done = 1'b0; bus_b.data_in = '0; bus_b.errors_in = '0; bus_b.out_ready = 1'b0;

    //      clr op din        err rdy | vld chk data       er cnt fl ov drop clean single multi
    // Single capture, then clear back to empty.
    add_vec(0, 1, 32'hA5,    0, 0,   1, 1, 32'hA5,    0, 1, 0, 0, 0, 1, 0, 0);
    add_vec(1, 0, 32'h0,     0, 0,   0, 0, 32'h0,     0, 0, 0, 0, 0, 0, 0, 0);
    // Fill 1..8 with codes 0,1,2,3 repeating; head stays 1.
    add_vec(0, 1, 32'd1,     0, 0,   1, 1, 32'd1,     0, 1, 0, 0, 0, 1, 0, 0);
    add_vec(0, 1, 32'd2,     1, 0,   1, 1, 32'd1,     0, 2, 0, 0, 0, 1, 1, 0);
    add_vec(0, 1, 32'd3,     2, 0,   1, 1, 32'd1,     0, 3, 0, 0, 0, 1, 1, 1);
    add_vec(0, 1, 32'd4,     3, 0,   1, 1, 32'd1,     0, 4, 0, 0, 0, 1, 1, 2);
    add_vec(0, 1, 32'd5,     0, 0,   1, 1, 32'd1,     0, 5, 0, 0, 0, 2, 1, 2);
    add_vec(0, 1, 32'd6,     1, 0,   1, 1, 32'd1,     0, 6, 0, 0, 0, 2, 2, 2);
    add_vec(0, 1, 32'd7,     2, 0,   1, 1, 32'd1,     0, 7, 0, 0, 0, 2, 2, 3);
    add_vec(0, 1, 32'd8,     3, 0,   1, 1, 32'd1,     0, 8, 1, 0, 0, 2, 2, 4);
    // Overflow: dropped, contents unchanged, single still counted.
    add_vec(0, 1, 32'hDEAD,  1, 0,   1, 1, 32'd1,     0, 8, 1, 1, 1, 2, 3, 4);
    // Full with simultaneous push/pop: no new drop.
    add_vec(0, 1, 32'h99,    0, 1,   1, 1, 32'd2,     1, 8, 1, 1, 1, 3, 3, 4);
    // Drain in order; 0x99 comes out after 8.
    add_vec(0, 0, 32'h0,     0, 1,   1, 1, 32'd3,     2, 7, 0, 1, 1, 3, 3, 4);
    add_vec(0, 0, 32'h0,     0, 1,   1, 1, 32'd4,     3, 6, 0, 1, 1, 3, 3, 4);
    add_vec(0, 0, 32'h0,     0, 1,   1, 1, 32'd5,     0, 5, 0, 1, 1, 3, 3, 4);
    add_vec(0, 0, 32'h0,     0, 1,   1, 1, 32'd6,     1, 4, 0, 1, 1, 3, 3, 4);
    add_vec(0, 0, 32'h0,     0, 1,   1, 1, 32'd7,     2, 3, 0, 1, 1, 3, 3, 4);
    add_vec(0, 0, 32'h0,     0, 1,   1, 1, 32'd8,     3, 2, 0, 1, 1, 3, 3, 4);
    add_vec(0, 0, 32'h0,     0, 1,   1, 1, 32'h99,    0, 1, 0, 1, 1, 3, 3, 4);
    add_vec(0, 0, 32'h0,     0, 1,   0, 0, 32'h0,     0, 0, 0, 1, 1, 3, 3, 4);
    // Ready with nothing held is ignored.
    add_vec(0, 0, 32'h0,     0, 1,   0, 0, 32'h0,     0, 0, 0, 1, 1, 3, 3, 4);
    // Three entries, then clear together with a push of 0x77.
    add_vec(0, 1, 32'h11,    0, 0,   1, 1, 32'h11,    0, 1, 0, 1, 1, 4, 3, 4);
    add_vec(0, 1, 32'h22,    2, 0,   1, 1, 32'h11,    0, 2, 0, 1, 1, 4, 3, 5);
    add_vec(0, 1, 32'h33,    1, 0,   1, 1, 32'h11,    0, 3, 0, 1, 1, 4, 4, 5);
    add_vec(1, 1, 32'h77,    0, 0,   0, 0, 32'h0,     0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 1, 32'h44,    0, 0,   1, 1, 32'h44,    0, 1, 0, 0, 0, 1, 0, 0);

    // Reset values while rst is held low.
    #12;
    check_a_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      v = vecs[i];
      clear = v.clr;
      bus_a.operation_done = v.op;
      bus_a.data_in = v.din;
      bus_a.errors_in = v.err;
      bus_a.out_ready = v.rdy;
      step();
      check("valid",  i, bus_a.out_valid, v.exp_valid);
      if (v.chk_data) begin
        check("data", i, bus_a.out_data, v.exp_data);
        check("errs", i, bus_a.out_errors, v.exp_errs);
      end
      check("count",  i, count_a, v.exp_count);
      check("full",   i, full_a, v.exp_full);
      check("ovf",    i, ovf_a, v.exp_ovf);
      check("drop",   i, drop_a, v.exp_drop);
      check("clean",  i, clean_a, v.exp_clean);
      check("single", i, single_a, v.exp_single);
      check("multi",  i, multi_a, v.exp_multi);
    end
    clear = 1'b0;

    // Async reset mid-drain: 0x44 held, add 0x55 and 0x66, pop one, then drop rst off-edge.
    bus_a.operation_done = 1'b1; bus_a.errors_in = 2'd0; bus_a.out_ready = 1'b0;
    bus_a.data_in = 32'h55;
    step();
    bus_a.data_in = 32'h66;
    step();
    bus_a.operation_done = 1'b0; bus_a.out_ready = 1'b1;
    step();
    check("drain_count", 0, count_a, 2);
    check("drain_head",  0, bus_a.out_data, 32'h55);
    #2 rst = 1'b0;
    #1 check_a_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    bus_a.operation_done = 1'b1; bus_a.data_in = 32'hAB; bus_a.errors_in = 2'd2;
    bus_a.out_ready = 1'b0;
    step();
    bus_a.operation_done = 1'b0;
    check("post_rst_valid", 0, bus_a.out_valid, 1);
    check("post_rst_count", 0, count_a, 1);
    check("post_rst_data",  0, bus_a.out_data, 32'hAB);
    check("post_rst_multi", 0, multi_a, 1);
    check("dead_seen",      0, dead_seen, 0);

    // Saturation on the 4-bit statistics instance: 20 clean pushes, none consumed.
    bus_b.operation_done = 1'b1; bus_b.errors_in = 2'd0; bus_b.out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bus_b.data_in = 32'(k);
      step();
    end
    check("sat_clean",  0, clean_b, 4'hF);
    check("sat_drop",   0, drop_b, 4'hC);
    check("sat_count",  0, count_b, 8);
    check("sat_ovf",    0, ovf_b, 1);
    check("sat_head",   0, bus_b.out_data, 0);
    // Five more single-error drops push drop_cnt past its ceiling.
    bus_b.errors_in = 2'd1;
    for (int k = 0; k < 5; k++) begin
      step();
    end
    bus_b.operation_done = 1'b0;
    check("sat_drop2",   0, drop_b, 4'hF);
    check("sat_single",  0, single_b, 5);
    check("sat_clean2",  0, clean_b, 4'hF);
    check("sat_multi",   0, multi_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
